dispensador_troco: RTL and testbench
====================================

DISPENSADOR_TROCO -- requirements
Module: dispensador_troco

Interface
REQ-001 SHALL have parameter PRECO_P0, default 4, price of product 0 in quarter units (4 = 1,00).
REQ-002 SHALL have parameter PRECO_P1, default 5, price of product 1 in quarter units (1,25).
REQ-003 SHALL have parameter PRECO_P2, default 6, price of product 2 in quarter units (1,50).
REQ-004 SHALL have parameter PRECO_P3, default 8, price of product 3 in quarter units (2,00).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port comparar, input, 1, end-of-purchase pulse from the coin accumulator.
REQ-008 SHALL have port valorAcumulado, input, 4, accumulated credit in quarter units (0..8).
REQ-009 SHALL have port produtoSel, input, 2, selected product index 0..3.
REQ-010 SHALL have port produtoRetirado, input, 1, acknowledge from the product dispenser.
REQ-011 SHALL have port trocoAceito, input, 1, acknowledge from the change-coin ejector.
REQ-012 SHALL have port liberaProduto, output, 1, request to release the selected product.
REQ-013 SHALL have port trocoValido, output, 1, trocoMoeda holds a coin to eject.
REQ-014 SHALL have port trocoMoeda, output, 2, coin code: 01 = 0,25; 10 = 0,50; 11 = 1,00; 00 = none.
REQ-015 SHALL have port insuficiente, output, 1, one-cycle pulse when credit is below price.
REQ-016 SHALL have port ocupado, output, 1, high in every state except OCIOSO.

Function
REQ-017 SHALL register all outputs; no combinational input-to-output path.
REQ-018 SHALL, in OCIOSO, capture valorAcumulado into a shadow register on every clock edge.
REQ-019 SHALL, on an edge with comparar=1 in OCIOSO, load saldo from the shadow register (the value of the previous cycle, since the accumulator clears itself as comparar rises), latch produtoSel, and go to COMPARA.
REQ-020 SHALL, in COMPARA (exactly 1 cycle), select preco from PRECO_P0..P3 by the latched index and apply one of REQ-021..REQ-023.
REQ-021 SHALL, if saldo=0, return to OCIOSO with no outputs asserted.
REQ-022 SHALL, if saldo>=preco, set resto=saldo-preco (4-bit, no underflow possible) and go to LIBERA with liberaProduto=1.
REQ-023 SHALL, if 0<saldo<preco, set resto=saldo, pulse insuficiente for 1 cycle, and go to TROCO (full refund).
REQ-024 SHALL hold liberaProduto=1 in LIBERA until produtoRetirado is sampled 1, then clear it and go to TROCO if resto>0, else OCIOSO.
REQ-025 SHALL, in TROCO, present the greedy coin: 11 if resto>=4; else 10 if resto>=2; else 01; with trocoValido=1.
REQ-026 SHALL hold trocoMoeda and trocoValido stable until trocoAceito is sampled 1, then subtract 4/2/1 from resto.
REQ-027 SHALL, when resto reaches 0 after a subtraction, clear trocoValido, set trocoMoeda=00, and go to OCIOSO on the same edge.
REQ-028 SHALL ignore comparar outside OCIOSO (no queueing, no error flag).
REQ-029 SHALL have a latency of 2 edges from comparar sampled to liberaProduto or insuficiente high.
REQ-030 SHALL treat an out-of-range saldo (9..15) as saldo=0 (REQ-021).

Reset
REQ-031 SHALL, on reset=1, immediately force state OCIOSO, saldo=0, resto=0, shadow=0, and all outputs 0, independent of clk.
REQ-032 SHALL abandon any transaction in progress when reset is asserted mid-operation; no change is owed after reset.

Verification
REQ-033 SHALL verify: shadow=6, produtoSel=0, comparar pulse -> liberaProduto high 2 edges later until ack; then one coin 10; ocupado falls.
REQ-034 SHALL verify: shadow=3, produtoSel=1 -> insuficiente 1-cycle pulse, no liberaProduto; coins 10 then 01.
REQ-035 SHALL verify: shadow=8, produtoSel=3 -> liberaProduto, no trocoValido, back to OCIOSO after ack.
REQ-036 SHALL verify: shadow=0 or 12, comparar -> no outputs; ocupado high for exactly 1 cycle.
REQ-037 SHALL verify: trocoAceito held low for 5 cycles in TROCO -> trocoMoeda stable; a comparar pulse during this window is ignored.
REQ-038 SHALL verify: reset asserted between clock edges in TROCO -> all outputs 0 before the next edge; a new transaction then completes normally.

Source files
------------

// File: rtl/dispensador_troco.sv
// Product release and change dispenser for a vending machine.
// On a purchase request it compares the captured credit with the price of the
// selected product, asks for the product to be released, and ejects the change
// (or the full refund) one greedy coin at a time with a handshake per coin.
module dispensador_troco #(
  parameter int PRECO_P0 = 4,
  parameter int PRECO_P1 = 5,
  parameter int PRECO_P2 = 6,
  parameter int PRECO_P3 = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       comparar,
  input  logic [3:0] valorAcumulado,
  input  logic [1:0] produtoSel,
  input  logic       produtoRetirado,
  input  logic       trocoAceito,
  output logic       liberaProduto,
  output logic       trocoValido,
  output logic [1:0] trocoMoeda,
  output logic       insuficiente,
  output logic       ocupado
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] COMPARA = 2'd1;
  localparam logic [1:0] LIBERA  = 2'd2;
  localparam logic [1:0] TROCO   = 2'd3;

  // Largest credit the coin accumulator can legally report.
  localparam logic [3:0] SALDO_MAX = 4'd8;

  logic [1:0] state_reg, state_next;
  logic [3:0] shadow_reg, shadow_next;
  logic [3:0] saldo_reg, saldo_next;
  logic [3:0] resto_reg, resto_next;
  logic [1:0] sel_reg, sel_next;
  logic       libera_reg, libera_next;
  logic       valido_reg, valido_next;
  logic [1:0] moeda_reg, moeda_next;
  logic       insuf_reg, insuf_next;
  logic       ocupado_reg, ocupado_next;

  logic [3:0] preco;
  logic [3:0] resto_sub;

  // Greedy coin choice for a given remaining amount (quarter units).
  function automatic logic [1:0] moeda_de(input logic [3:0] valor);
    if (valor >= 4'd4)      moeda_de = 2'b11;
    else if (valor >= 4'd2) moeda_de = 2'b10;
    else                    moeda_de = 2'b01;
  endfunction

  // Value in quarter units of a coin code.
  function automatic logic [3:0] valor_de(input logic [1:0] moeda);
    case (moeda)
      2'b11:   valor_de = 4'd4;
      2'b10:   valor_de = 4'd2;
      2'b01:   valor_de = 4'd1;
      default: valor_de = 4'd0;
    endcase
  endfunction

  // Price lookup by the index latched at the start of the purchase.
  always_comb begin
    case (sel_reg)
      2'd0:    preco = 4'(PRECO_P0);
      2'd1:    preco = 4'(PRECO_P1);
      2'd2:    preco = 4'(PRECO_P2);
      default: preco = 4'(PRECO_P3);
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    saldo_next  = saldo_reg;
    resto_next  = resto_reg;
    sel_next    = sel_reg;
    libera_next = libera_reg;
    valido_next = valido_reg;
    moeda_next  = moeda_reg;
    insuf_next  = 1'b0;
    resto_sub   = resto_reg - valor_de(moeda_reg);

    case (state_reg)
      OCIOSO: begin
        // The accumulator clears as comparar rises, so the purchase uses the
        // credit captured on the previous edge.
        shadow_next = valorAcumulado;
        if (comparar) begin
          saldo_next = shadow_reg;
          sel_next   = produtoSel;
          state_next = COMPARA;
        end
      end
      COMPARA: begin
        if (saldo_reg == 4'd0 || saldo_reg > SALDO_MAX) begin
          state_next = OCIOSO;
        end else if (saldo_reg >= preco) begin
          resto_next  = saldo_reg - preco;
          libera_next = 1'b1;
          state_next  = LIBERA;
        end else begin
          resto_next  = saldo_reg;
          insuf_next  = 1'b1;
          valido_next = 1'b1;
          moeda_next  = moeda_de(saldo_reg);
          state_next  = TROCO;
        end
      end
      LIBERA: begin
        if (produtoRetirado) begin
          libera_next = 1'b0;
          if (resto_reg != 4'd0) begin
            valido_next = 1'b1;
            moeda_next  = moeda_de(resto_reg);
            state_next  = TROCO;
          end else begin
            state_next = OCIOSO;
          end
        end
      end
      TROCO: begin
        if (trocoAceito) begin
          resto_next = resto_sub;
          if (resto_sub == 4'd0) begin
            valido_next = 1'b0;
            moeda_next  = 2'b00;
            state_next  = OCIOSO;
          end else begin
            moeda_next = moeda_de(resto_sub);
          end
        end
      end
      default: state_next = OCIOSO;
    endcase

    ocupado_next = (state_next != OCIOSO);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= OCIOSO;
      shadow_reg  <= 4'd0;
      saldo_reg   <= 4'd0;
      resto_reg   <= 4'd0;
      sel_reg     <= 2'd0;
      libera_reg  <= 1'b0;
      valido_reg  <= 1'b0;
      moeda_reg   <= 2'b00;
      insuf_reg   <= 1'b0;
      ocupado_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shadow_reg  <= shadow_next;
      saldo_reg   <= saldo_next;
      resto_reg   <= resto_next;
      sel_reg     <= sel_next;
      libera_reg  <= libera_next;
      valido_reg  <= valido_next;
      moeda_reg   <= moeda_next;
      insuf_reg   <= insuf_next;
      ocupado_reg <= ocupado_next;
    end
  end

  assign liberaProduto = libera_reg;
  assign trocoValido   = valido_reg;
  assign trocoMoeda    = moeda_reg;
  assign insuficiente  = insuf_reg;
  assign ocupado       = ocupado_reg;

endmodule

// File: tb/tb_dispensador_troco.sv
// Self-checking bench for dispensador_troco: directed vector table, hand-made
// corner sequences and randomized purchases against a price/change model.
module tb_dispensador_troco;

  logic       clk;
  logic       reset;
  logic       comparar;
  logic [3:0] valorAcumulado;
  logic [1:0] produtoSel;
  logic       produtoRetirado;
  logic       trocoAceito;
  logic       liberaProduto;
  logic       trocoValido;
  logic [1:0] trocoMoeda;
  logic       insuficiente;
  logic       ocupado;

  int checks   = 0;
  int failures = 0;

  dispensador_troco dut (
    .clk             (clk),
    .reset           (reset),
    .comparar        (comparar),
    .valorAcumulado  (valorAcumulado),
    .produtoSel      (produtoSel),
    .produtoRetirado (produtoRetirado),
    .trocoAceito     (trocoAceito),
    .liberaProduto   (liberaProduto),
    .trocoValido     (trocoValido),
    .trocoMoeda      (trocoMoeda),
    .insuficiente    (insuficiente),
    .ocupado         (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    int v;
    int sel;
    int lib;
    int insuf;
    int change;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock: inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural model of a purchase from the price table.
  function automatic void model(input int v, input int sel,
                                output int lib, output int insuf, output int change);
    int precos[4];
    int credito;
    precos = '{4, 5, 6, 8};
    credito = (v > 8) ? 0 : v;
    lib = 0; insuf = 0; change = 0;
    if (credito == 0) begin
      change = 0;
    end else if (credito >= precos[sel]) begin
      lib = 1;
      change = credito - precos[sel];
    end else begin
      insuf = 1;
      change = credito;
    end
  endfunction

  // Coin codes expected for a change amount: dollars, then halves, then quarters.
  function automatic void coins_for(input int change, output int q[$]);
    q = {};
    for (int i = 0; i < change / 4; i++) q.push_back(3);
    for (int i = 0; i < (change % 4) / 2; i++) q.push_back(2);
    for (int i = 0; i < change % 2; i++) q.push_back(1);
  endfunction

  // Presents credit, pulses comparar and advances to the decision edge.
  task automatic start_txn(input int v, input int sel);
    valorAcumulado = 4'(v);
    produtoSel     = 2'(sel);
    tick();
    comparar       = 1'b1;
    valorAcumulado = 4'd0;
    tick();
    comparar   = 1'b0;
    produtoSel = 2'(sel + 1);   // selection must already be latched
    check("ocupado_after_comparar", int'(ocupado), 1);
    check("libera_early", int'(liberaProduto), 0);
    check("insuf_early", int'(insuficiente), 0);
    tick();
  endtask

  // Full purchase with handshakes; hold = idle cycles before each coin ack.
  task automatic run_txn(input string tag, input int v, input int sel,
                         input int lib, input int insuf, input int change,
                         input int hold, input bit poke);
    int q[$];
    coins_for(change, q);
    $display("txn %s v=%0d sel=%0d lib=%0d insuf=%0d change=%0d", tag, v, sel, lib, insuf, change);
    start_txn(v, sel);
    check({tag, "_libera"}, int'(liberaProduto), lib);
    check({tag, "_insuf"}, int'(insuficiente), insuf);
    if (lib == 0 && insuf == 0) begin
      check({tag, "_ocupado_1cyc"}, int'(ocupado), 0);
      check({tag, "_valido_none"}, int'(trocoValido), 0);
      return;
    end
    if (lib == 1) begin
      repeat (2) begin
        tick();
        check({tag, "_libera_hold"}, int'(liberaProduto), 1);
      end
      produtoRetirado = 1'b1;
      tick();
      produtoRetirado = 1'b0;
      check({tag, "_libera_clear"}, int'(liberaProduto), 0);
    end else begin
      tick();
      check({tag, "_insuf_pulse"}, int'(insuficiente), 0);
    end
    for (int i = 0; i < q.size(); i++) begin
      check({tag, "_valido"}, int'(trocoValido), 1);
      check({tag, "_moeda"}, int'(trocoMoeda), q[i]);
      for (int h = 0; h < hold; h++) begin
        if (poke && i == 0 && h == 1) comparar = 1'b1;
        tick();
        comparar = 1'b0;
        check({tag, "_moeda_stable"}, int'(trocoMoeda), q[i]);
        check({tag, "_valido_stable"}, int'(trocoValido), 1);
        check({tag, "_no_libera"}, int'(liberaProduto), 0);
      end
      trocoAceito = 1'b1;
      tick();
      trocoAceito = 1'b0;
    end
    check({tag, "_valido_end"}, int'(trocoValido), 0);
    check({tag, "_moeda_end"}, int'(trocoMoeda), 0);
    check({tag, "_ocupado_end"}, int'(ocupado), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int lib, insuf, change, v, sel;

    vecs[0] = '{6, 0, 1, 0, 2};
    vecs[1] = '{3, 1, 0, 1, 3};
    vecs[2] = '{8, 3, 1, 0, 0};
    vecs[3] = '{0, 2, 0, 0, 0};
    vecs[4] = '{12, 0, 0, 0, 0};
    vecs[5] = '{5, 1, 1, 0, 0};
    vecs[6] = '{7, 2, 1, 0, 1};
    vecs[7] = '{1, 3, 0, 1, 1};

    reset = 1'b1; comparar = 1'b0; valorAcumulado = 4'd0; produtoSel = 2'd0;
    produtoRetirado = 1'b0; trocoAceito = 1'b0;
    tick();
    tick();
    check("rst_libera", int'(liberaProduto), 0);
    check("rst_valido", int'(trocoValido), 0);
    check("rst_moeda", int'(trocoMoeda), 0);
    check("rst_insuf", int'(insuficiente), 0);
    check("rst_ocupado", int'(ocupado), 0);
    reset = 1'b0;
    tick();

    // Directed vectors.
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].v, vecs[i].sel,
              vecs[i].lib, vecs[i].insuf, vecs[i].change, 1, 1'b0);

    // Change held back for 5 cycles with a stray comparar in the window.
    run_txn("hold", 7, 0, 1, 0, 3, 5, 1'b1);

    // Reset between edges while ejecting change.
    $display("txn reset_mid v=3 sel=1");
    start_txn(3, 1);
    check("rm_insuf", int'(insuficiente), 1);
    tick();
    check("rm_valido_pre", int'(trocoValido), 1);
    #2 reset = 1'b1;
    #1;
    check("rm_libera", int'(liberaProduto), 0);
    check("rm_valido", int'(trocoValido), 0);
    check("rm_moeda", int'(trocoMoeda), 0);
    check("rm_insuf0", int'(insuficiente), 0);
    check("rm_ocupado", int'(ocupado), 0);
    reset = 1'b0;
    @(negedge clk);
    tick();
    check("rm_idle", int'(ocupado), 0);
    run_txn("after_rst", 6, 0, 1, 0, 2, 0, 1'b0);

    // Randomized purchases checked against the model.
    for (int i = 0; i < 40; i++) begin
      v   = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 3));
      model(v, sel, lib, insuf, change);
      run_txn($sformatf("rnd%0d", i), v, sel, lib, insuf, change,
              int'($urandom_range(0, 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
